// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with a small input FIFO and fixed clocks-per-bit divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] rd_idx;
  logic          full, empty, push, pop;

  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        bit_done, advance, tx_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign rd_idx   = rd_ptr[AW-1:0];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ready    = !full;
  assign push     = valid && !full;
  assign busy     = (state != IDLE) || !empty;
  assign bit_done = (baud_cnt == BAUD_LAST);

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done) begin
`ifdef UART_TX_PARITY_EN
          if (bit_cnt == 3'd7) state_next = PARITY;
`else
          if (bit_cnt == 3'd7) state_next = STOP;
`endif
          else                 advance    = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level for the coming cycle, computed from the next state so tx can be a plain flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_next)
      START:  tx_d = 1'b0;
      DATA:   tx_d = advance ? shift[1] : shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments so every flop here samples pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift    <= mem[rd_idx];
        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^mem[rd_idx];
`endif
      end else if (advance) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state_next != state) || advance || (state_next == IDLE)) baud_cnt <= '0;
      else                                                          baud_cnt <= baud_cnt + 16'd1;
      tx <= tx_d;
    end
  end

endmodule
